log_reader_req_arb: RTL and testbench

Round-robin arbiter and sequencer that shares the single log reader between NUM_REQ requesters, e.g. the state-transfer and get-state paths. It accepts one log-range read request at a time, issues it to the reader, and steers the resulting entry stream to the granting requester's sink. It holds the grant until the reader's last beat is accepted, then re-arbitrates. It sits between the request sources and the log reader's request and output ports.

---
 rtl/log_reader_req_arb.sv | 234 +++++++++++++++++++++++
 tb/tb_log_reader_req_arb.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/log_reader_req_arb.sv
`timescale 1ns/1ps
// log_reader_req_arb: round-robin arbiter and sequencer that shares one log
// reader between NUM_REQ requesters. It accepts one log-range request at a
// time, issues it to the reader, and steers the resulting entry stream to the
// granted requester's sink until the last beat is accepted.
//
// Optional feature: define LOG_READER_ARB_WDOG_EN to enable a stall watchdog
// in STREAM (limit WDOG_CYCLES). Without it, wdog_err is tied low and STREAM
// waits indefinitely for the last beat.
module log_reader_req_arb #(
  parameter int NUM_REQ     = 2,
  parameter int IDX_W       = 32,
  parameter int DATA_W      = 512,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic                           clk,
  input  logic                           rst,
  // requester side
  input  logic [NUM_REQ-1:0]             req_val,
  input  logic [NUM_REQ*IDX_W-1:0]       req_start_idx,
  input  logic [NUM_REQ*IDX_W-1:0]       req_end_idx,
  output logic [NUM_REQ-1:0]             req_rdy,
  // reader request port
  output logic                           arb_reader_req_val,
  output logic [IDX_W-1:0]               arb_reader_req_start_idx,
  output logic [IDX_W-1:0]               arb_reader_req_end_idx,
  input  logic                           reader_arb_req_rdy,
  // reader stream port
  input  logic                           reader_arb_data_val,
  input  logic [DATA_W-1:0]              reader_arb_data,
  input  logic                           reader_arb_data_last,
  output logic                           arb_reader_data_rdy,
  // sink side
  output logic [NUM_REQ-1:0]             arb_dst_data_val,
  output logic [DATA_W-1:0]              arb_dst_data,
  output logic                           arb_dst_data_last,
  input  logic [NUM_REQ-1:0]             dst_arb_data_rdy,
  // status
  output logic                           busy,
  output logic [$clog2(NUM_REQ)-1:0]     grant_idx,
  output logic                           wdog_err
);

  localparam int GNT_W = $clog2(NUM_REQ);

  // Elaboration-time sanity checks on the configuration.
  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("log_reader_req_arb: NUM_REQ must be at least 2");
  end
  if (WDOG_CYCLES < 1) begin : g_bad_wdog_cycles
    $error("log_reader_req_arb: WDOG_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

  state_e             state_q,     state_d;
  logic [GNT_W-1:0]   rr_ptr_q,    rr_ptr_d;
  logic [GNT_W-1:0]   grant_q,     grant_d;
  logic [IDX_W-1:0]   start_idx_q, start_idx_d;
  logic [IDX_W-1:0]   end_idx_q,   end_idx_d;

  logic [IDX_W-1:0]   start_arr [NUM_REQ];
  logic [IDX_W-1:0]   end_arr   [NUM_REQ];

  logic               arb_found;
  logic [GNT_W-1:0]   arb_winner;
  logic [GNT_W-1:0]   arb_cand;

  logic               stream_hs;
  logic               wdog_trip;

  // Unpack the per-requester index buses into arrays for clean indexing.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign start_arr[gi] = req_start_idx[gi*IDX_W +: IDX_W];
    assign end_arr[gi]   = req_end_idx[gi*IDX_W +: IDX_W];
  end

  // Increment a requester index with wrap at NUM_REQ (works for non-power-of-2).
  function automatic logic [GNT_W-1:0] wrap_inc(input logic [GNT_W-1:0] p);
    if (p == GNT_W'(NUM_REQ - 1)) begin
      return '0;
    end
    return p + GNT_W'(1);
  endfunction

  // A beat moves only while streaming and the granted sink is ready.
  assign stream_hs = (state_q == ST_STREAM) && reader_arb_data_val
                     && dst_arb_data_rdy[grant_q];

  // Round-robin search: first valid requester at or above rr_ptr, with wrap.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    arb_found  = 1'b0;
    arb_winner = rr_ptr_q;
    arb_cand   = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!arb_found && req_val[arb_cand]) begin
        arb_found  = 1'b1;
        arb_winner = arb_cand;
      end
      arb_cand = wrap_inc(arb_cand);
    end
  end

  // Next-state and handshake outputs for the IDLE/ISSUE/STREAM sequencer.
  always_comb begin
    state_d             = state_q;
    rr_ptr_d            = rr_ptr_q;
    grant_d             = grant_q;
    start_idx_d         = start_idx_q;
    end_idx_d           = end_idx_q;
    req_rdy             = '0;
    arb_dst_data_val    = '0;
    arb_reader_data_rdy = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Accept is suppressed during reset so a requester never sees its
        // request taken on a cycle whose effects are about to be discarded.
        if (arb_found && !rst) begin
          req_rdy[arb_winner] = 1'b1;
          start_idx_d         = start_arr[arb_winner];
          end_idx_d           = end_arr[arb_winner];
          grant_d             = arb_winner;
          if (start_arr[arb_winner] != end_arr[arb_winner]) begin
            state_d = ST_ISSUE;
          end else begin
            // Zero-length range: nothing to read, just move the pointer on.
            rr_ptr_d = wrap_inc(arb_winner);
          end
        end
      end

      ST_ISSUE: begin
        if (reader_arb_req_rdy) begin
          state_d = ST_STREAM;
        end
      end

      ST_STREAM: begin
        arb_dst_data_val[grant_q] = reader_arb_data_val;
        arb_reader_data_rdy       = dst_arb_data_rdy[grant_q];
        if (stream_hs && reader_arb_data_last) begin
          state_d  = ST_IDLE;
          rr_ptr_d = wrap_inc(grant_q);
        end else if (wdog_trip) begin
          state_d  = ST_IDLE;
          rr_ptr_d = wrap_inc(grant_q);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, round-robin pointer, grant and latched indices.
  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      start_idx_q <= '0;
      end_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      start_idx_q <= start_idx_d;
      end_idx_q   <= end_idx_d;
    end
  end

`ifdef LOG_READER_ARB_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic              wdog_err_q, wdog_err_d;

  // Stall counter: cleared on STREAM entry and on every beat, trips at the limit.
  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    wdog_err_d = wdog_err_q;
    wdog_trip  = 1'b0;
    if (state_q == ST_ISSUE) begin
      wdog_cnt_d = '0;
    end else if (state_q == ST_STREAM) begin
      if (stream_hs) begin
        wdog_cnt_d = '0;
      end else if (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1)) begin
        wdog_trip  = 1'b1;
        wdog_err_d = 1'b1;
        wdog_cnt_d = '0;
      end else begin
        wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
      end
    end
  end

  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  assign wdog_trip = 1'b0;
  assign wdog_err  = 1'b0;
`endif

  // Request port, stream passthrough and status.
  assign arb_reader_req_val       = (state_q == ST_ISSUE);
  assign arb_reader_req_start_idx = start_idx_q;
  assign arb_reader_req_end_idx   = end_idx_q;
  assign arb_dst_data             = reader_arb_data;
  assign arb_dst_data_last        = reader_arb_data_last;
  assign busy                     = (state_q != ST_IDLE);
  assign grant_idx                = grant_q;

endmodule

// File: tb/tb_log_reader_req_arb.sv
`timescale 1ns/1ps
// Bench for log_reader_req_arb: a cycle-by-cycle table of inputs and expected
// outputs, followed by hand-written back-to-back and watchdog sequences.
module tb_log_reader_req_arb;

  localparam int NUM_REQ = 2;
  localparam int IDX_W   = 32;
  localparam int DATA_W  = 512;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_val;
  logic [NUM_REQ*IDX_W-1:0] req_start_idx;
  logic [NUM_REQ*IDX_W-1:0] req_end_idx;
  logic [NUM_REQ-1:0]       req_rdy;
  logic                     arb_reader_req_val;
  logic [IDX_W-1:0]         arb_reader_req_start_idx;
  logic [IDX_W-1:0]         arb_reader_req_end_idx;
  logic                     reader_arb_req_rdy;
  logic                     reader_arb_data_val;
  logic [DATA_W-1:0]        reader_arb_data;
  logic                     reader_arb_data_last;
  logic                     arb_reader_data_rdy;
  logic [NUM_REQ-1:0]       arb_dst_data_val;
  logic [DATA_W-1:0]        arb_dst_data;
  logic                     arb_dst_data_last;
  logic [NUM_REQ-1:0]       dst_arb_data_rdy;
  logic                     busy;
  logic [0:0]               grant_idx;
  logic                     wdog_err;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] cur_dat;

  log_reader_req_arb #(
    .NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .DATA_W(DATA_W), .WDOG_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_val(req_val), .req_start_idx(req_start_idx), .req_end_idx(req_end_idx),
    .req_rdy(req_rdy),
    .arb_reader_req_val(arb_reader_req_val),
    .arb_reader_req_start_idx(arb_reader_req_start_idx),
    .arb_reader_req_end_idx(arb_reader_req_end_idx),
    .reader_arb_req_rdy(reader_arb_req_rdy),
    .reader_arb_data_val(reader_arb_data_val), .reader_arb_data(reader_arb_data),
    .reader_arb_data_last(reader_arb_data_last),
    .arb_reader_data_rdy(arb_reader_data_rdy),
    .arb_dst_data_val(arb_dst_data_val), .arb_dst_data(arb_dst_data),
    .arb_dst_data_last(arb_dst_data_last), .dst_arb_data_rdy(dst_arb_data_rdy),
    .busy(busy), .grant_idx(grant_idx), .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [1:0] rv;
    logic [7:0] s0, e0, s1, e1;
    logic       rrdy, dval;
    logic [7:0] dat;
    logic       dlast;
    logic [1:0] drdy;
  } in_t;

  typedef struct packed {
    logic [1:0]  req_rdy;
    logic        rq_val;
    logic [31:0] rq_s, rq_e;
    logic        data_rdy;
    logic [1:0]  dst_val;
    logic        last, busy, grant, wdog, data_ok;
  } obs_t;

  typedef struct packed {
    in_t  i;
    obs_t o;
  } vec_t;

  vec_t vecs[$];

  function automatic in_t mi(input int rst_v, input int rv, input int s0, input int e0,
                             input int s1, input int e1, input int rrdy, input int dval,
                             input int dat, input int dlast, input int drdy);
    in_t r;
    r.rst = rst_v[0];  r.rv = rv[1:0];
    r.s0 = s0[7:0];    r.e0 = e0[7:0];  r.s1 = s1[7:0];  r.e1 = e1[7:0];
    r.rrdy = rrdy[0];  r.dval = dval[0];
    r.dat = dat[7:0];  r.dlast = dlast[0];  r.drdy = drdy[1:0];
    return r;
  endfunction

  function automatic obs_t mo(input int rr, input int rqv, input int rs, input int re,
                              input int drdy, input int dv, input int last,
                              input int bsy, input int g);
    obs_t o;
    o.req_rdy = rr[1:0];  o.rq_val = rqv[0];
    o.rq_s = {24'd0, rs[7:0]};  o.rq_e = {24'd0, re[7:0]};
    o.data_rdy = drdy[0];  o.dst_val = dv[1:0];  o.last = last[0];
    o.busy = bsy[0];  o.grant = g[0];  o.wdog = 1'b0;  o.data_ok = 1'b1;
    return o;
  endfunction

  task automatic add(input in_t i, input obs_t o);
    vecs.push_back('{i: i, o: o});
  endtask

  task automatic apply_in(input in_t x);
    rst                  = x.rst;
    req_val              = x.rv;
    req_start_idx        = {24'd0, x.s1, 24'd0, x.s0};
    req_end_idx          = {24'd0, x.e1, 24'd0, x.e0};
    reader_arb_req_rdy   = x.rrdy;
    reader_arb_data_val  = x.dval;
    reader_arb_data      = {64{x.dat}};
    reader_arb_data_last = x.dlast;
    dst_arb_data_rdy     = x.drdy;
    cur_dat              = x.dat;
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.req_rdy  = req_rdy;
    o.rq_val   = arb_reader_req_val;
    o.rq_s     = arb_reader_req_start_idx;
    o.rq_e     = arb_reader_req_end_idx;
    o.data_rdy = arb_reader_data_rdy;
    o.dst_val  = arb_dst_data_val;
    o.last     = arb_dst_data_last;
    o.busy     = busy;
    o.grant    = grant_idx[0];
    o.wdog     = wdog_err;
    o.data_ok  = (arb_dst_data == {64{cur_dat}});
    return o;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input in_t x);
    @(negedge clk);
    apply_in(x);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ovh;

    // Columns: mi(rst, req_val, s0, e0, s1, e1, rd_req_rdy, rd_val, data, last, sink_rdy)
    //          mo(req_rdy, rq_val, rq_s, rq_e, data_rdy, dst_val, last, busy, grant)
    // Single requester 0, range 5..8, three beats.
    add(mi(0,0,0,0,0,0,0,0,'h00,0,0), mo(0,0,0,0,0,0,0,0,0));
    add(mi(0,1,5,8,0,0,0,0,'h00,0,0), mo(1,0,0,0,0,0,0,0,0));
    add(mi(0,0,5,8,0,0,0,0,'h00,0,0), mo(0,1,5,8,0,0,0,1,0));
    add(mi(0,0,0,0,0,0,1,0,'h00,0,0), mo(0,1,5,8,0,0,0,1,0));
    add(mi(0,0,0,0,0,0,0,1,'hA1,0,1), mo(0,0,5,8,1,1,0,1,0));
    add(mi(0,0,0,0,0,0,0,1,'hA2,0,1), mo(0,0,5,8,1,1,0,1,0));
    add(mi(0,0,0,0,0,0,0,1,'hA3,1,1), mo(0,0,5,8,1,1,1,1,0));
    // Reader valid outside STREAM is neither accepted nor forwarded.
    add(mi(0,0,0,0,0,0,0,1,'hA4,0,3), mo(0,0,5,8,0,0,0,0,0));
    // Reset with requests pending: no accept during reset.
    add(mi(1,3,0,0,0,0,0,0,'h00,0,0), mo(0,0,5,8,0,0,0,0,0));
    // Both requesters valid, one-beat reads: grants 0,1,0,1.
    add(mi(0,3,1,2,3,4,0,0,'h00,0,0), mo(1,0,0,0,0,0,0,0,0));
    add(mi(0,3,1,2,3,4,1,0,'h00,0,0), mo(0,1,1,2,0,0,0,1,0));
    add(mi(0,3,1,2,3,4,0,1,'hB0,1,3), mo(0,0,1,2,1,1,1,1,0));
    add(mi(0,3,1,2,3,4,0,0,'h00,0,0), mo(2,0,1,2,0,0,0,0,0));
    add(mi(0,3,1,2,3,4,1,0,'h00,0,0), mo(0,1,3,4,0,0,0,1,1));
    add(mi(0,3,1,2,3,4,0,1,'hB1,1,3), mo(0,0,3,4,1,2,1,1,1));
    add(mi(0,3,1,2,3,4,0,0,'h00,0,0), mo(1,0,3,4,0,0,0,0,1));
    add(mi(0,3,1,2,3,4,1,0,'h00,0,0), mo(0,1,1,2,0,0,0,1,0));
    add(mi(0,3,1,2,3,4,0,1,'hB2,1,3), mo(0,0,1,2,1,1,1,1,0));
    add(mi(0,3,1,2,3,4,0,0,'h00,0,0), mo(2,0,1,2,0,0,0,0,0));
    add(mi(0,3,1,2,3,4,1,0,'h00,0,0), mo(0,1,3,4,0,0,0,1,1));
    add(mi(0,3,1,2,3,4,0,1,'hB3,1,3), mo(0,0,3,4,1,2,1,1,1));
    // Zero-length on requester 1 (pointer to 0), then on requester 0 (pointer to 1).
    add(mi(0,2,0,0,10,10,0,0,'h00,0,0), mo(2,0,3,4,0,0,0,0,1));
    add(mi(0,3,7,7,30,31,0,0,'h00,0,0), mo(1,0,10,10,0,0,0,0,1));
    add(mi(0,3,7,7,30,31,0,0,'h00,0,0), mo(2,0,7,7,0,0,0,0,0));
    add(mi(0,0,0,0,0,0,0,0,'h00,0,0), mo(0,1,30,31,0,0,0,1,1));
    add(mi(0,0,0,0,0,0,1,0,'h00,0,0), mo(0,1,30,31,0,0,0,1,1));
    // Four-beat stream to sink 1 with its ready toggling; reader holds stalled beats.
    add(mi(0,0,0,0,0,0,0,1,'hD0,0,2), mo(0,0,30,31,1,2,0,1,1));
    add(mi(0,0,0,0,0,0,0,1,'hD1,0,0), mo(0,0,30,31,0,2,0,1,1));
    add(mi(0,0,0,0,0,0,0,1,'hD1,0,2), mo(0,0,30,31,1,2,0,1,1));
    add(mi(0,0,0,0,0,0,0,1,'hD2,0,1), mo(0,0,30,31,0,2,0,1,1));
    add(mi(0,0,0,0,0,0,0,1,'hD2,0,3), mo(0,0,30,31,1,2,0,1,1));
    add(mi(0,0,0,0,0,0,0,1,'hD3,1,0), mo(0,0,30,31,0,2,1,1,1));
    add(mi(0,0,0,0,0,0,0,0,'h00,0,2), mo(0,0,30,31,1,0,0,1,1));
    add(mi(0,0,0,0,0,0,0,1,'hD3,1,2), mo(0,0,30,31,1,2,1,1,1));
    add(mi(0,0,0,0,0,0,0,0,'h00,0,0), mo(0,0,30,31,0,0,0,0,1));
    // Reset after beat 2 of 4, then a start>end request goes out unmodified.
    add(mi(0,1,40,44,0,0,0,0,'h00,0,0), mo(1,0,30,31,0,0,0,0,1));
    add(mi(0,0,0,0,0,0,1,0,'h00,0,0), mo(0,1,40,44,0,0,0,1,0));
    add(mi(0,0,0,0,0,0,0,1,'hE0,0,1), mo(0,0,40,44,1,1,0,1,0));
    add(mi(0,0,0,0,0,0,0,1,'hE1,0,1), mo(0,0,40,44,1,1,0,1,0));
    add(mi(1,0,0,0,0,0,0,1,'hE2,0,1), mo(0,0,40,44,1,1,0,1,0));
    add(mi(0,0,0,0,0,0,0,0,'h00,0,0), mo(0,0,0,0,0,0,0,0,0));
    add(mi(0,2,0,0,60,50,0,0,'h00,0,0), mo(2,0,0,0,0,0,0,0,0));
    add(mi(0,0,0,0,0,0,1,0,'h00,0,0), mo(0,1,60,50,0,0,0,1,1));
    add(mi(0,0,0,0,0,0,0,1,'hF0,1,2), mo(0,0,60,50,1,2,1,1,1));
    add(mi(0,0,0,0,0,0,0,0,'h00,0,0), mo(0,0,60,50,0,0,0,0,1));

    // Initial reset.
    apply_in(mi(1,0,0,0,0,0,0,0,0,0,0));
    repeat (2) @(negedge clk);

    for (int r = 0; r < vecs.size(); r++) begin
      step(vecs[r].i);
      check($sformatf("vec%0d", r), 128'(sample()), 128'(vecs[r].o));
    end

    // Back-to-back: next reader request arrives two cycles after the last beat.
    step(mi(0,1,1,2,0,0,0,0,0,0,0));
    check("b2b_accept", 128'(req_rdy), 128'(1));
    step(mi(0,1,1,2,0,0,1,0,0,0,0));
    check("b2b_issue", 128'(arb_reader_req_val), 128'(1));
    step(mi(0,1,1,2,0,0,0,1,'hC0,1,1));
    check("b2b_last_beat", 128'({arb_dst_data_val, arb_reader_data_rdy}), 128'(3'b011));
    ovh = 0;
    for (int c = 1; c <= 10; c++) begin
      step(mi(0,1,1,2,0,0,0,0,0,0,0));
      if (arb_reader_req_val) begin
        ovh = c;
        break;
      end
    end
    check("b2b_overhead_cycles", 128'(ovh), 128'(2));
    apply_in(mi(0,0,1,2,0,0,1,0,0,0,0));
    step(mi(0,0,0,0,0,0,0,1,'hC1,1,1));
    check("b2b_second_beat", 128'(arb_dst_data_val), 128'(1));
    step(mi(0,0,0,0,0,0,0,0,0,0,0));
    check("b2b_idle", 128'(busy), 128'(0));

`ifdef LOG_READER_ARB_WDOG_EN
    // Watchdog: reader stalls after beat 1; trips after 16 stall cycles.
    apply_in(mi(1,0,0,0,0,0,0,0,0,0,0));
    repeat (2) @(negedge clk);
    step(mi(0,3,1,2,3,4,0,0,0,0,0));
    check("wd_accept", 128'(req_rdy), 128'(1));
    step(mi(0,3,1,2,3,4,1,0,0,0,0));
    check("wd_issue", 128'(arb_reader_req_val), 128'(1));
    step(mi(0,3,1,2,3,4,0,1,'hD0,0,3));
    check("wd_beat1", 128'(arb_dst_data_val), 128'(1));
    for (int s = 1; s <= 16; s++) begin
      step(mi(0,3,1,2,3,4,0,0,0,0,3));
      check($sformatf("wd_stall%0d", s), 128'({wdog_err, busy}), 128'(2'b01));
    end
    step(mi(0,3,1,2,3,4,0,0,0,0,3));
    check("wd_trip", 128'({wdog_err, busy, req_rdy}), 128'(4'b1010));
    step(mi(0,0,0,0,0,0,0,0,0,0,0));
    check("wd_sticky", 128'(wdog_err), 128'(1));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
